// File: rtl/mux9_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux9_arb_pkg
// Shared constants and types for the 9-input round-robin mux arbiter.
//   NUM_IN         : number of requesters (fixed at 9)
//   SEL_W          : width of the mux select / grant index
//   RST_LAST_GRANT : pointer value after reset, so index 0 has top priority
//   sel_t          : requester index type
//   req_vec_t      : one bit per requester (valid / grant vectors)
//   ostage_t       : output stage state (EMPTY / FULL)
// ---------------------------------------------------------------------------
package mux9_arb_pkg;

   localparam int NUM_IN = 9;
   localparam int SEL_W  = 4;

   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [NUM_IN-1:0] req_vec_t;

   localparam sel_t RST_LAST_GRANT = 4'd8;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } ostage_t;

endpackage

// File: rtl/rr_pick9.sv
// ---------------------------------------------------------------------------
// rr_pick9
// Purely combinational round-robin picker over nine requesters.
// The search starts at last+1 and wraps from 8 back to 0; the first
// requester found with its request bit set wins.
//   req       : request vector, bit i belongs to requester i
//   last      : index of the most recent grant
//   grant_oh  : one-hot grant (all-zero when nothing is requested)
//   grant_idx : binary index of the winner (0 when nothing is requested)
//   any_req   : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick9
   import mux9_arb_pkg::*;
(
   input  req_vec_t req,
   input  sel_t     last,
   output req_vec_t grant_oh,
   output sel_t     grant_idx,
   output logic     any_req
);

   // Candidate index held one bit wider so last+k never overflows before
   // the modulo-9 fold.
   logic [SEL_W:0] cand;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         cand = {1'b0, last} + (SEL_W+1)'(k);
         // Two folds keep the index in 0..8 even for an out-of-range pointer.
         if (cand >= (SEL_W+1)'(NUM_IN)) cand = cand - (SEL_W+1)'(NUM_IN);
         if (cand >= (SEL_W+1)'(NUM_IN)) cand = cand - (SEL_W+1)'(NUM_IN);
         if (!any_req && req[cand[SEL_W-1:0]]) begin
            any_req                    = 1'b1;
            grant_idx                  = cand[SEL_W-1:0];
            grant_oh[cand[SEL_W-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux9_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux9_rr_arbiter
// Round-robin arbiter and scheduler for a shared 9-input word multiplexer.
// One requester is granted per cycle; the selected word is registered into
// a single-entry output stage with a valid/ready handshake.
//
// Ports:
//   CGRA_Clock   : clock, all state updates on the rising edge
//   CGRA_Reset   : synchronous active-high reset
//   CGRA_Enable  : global stall; low means no transfer and all state holds
//   in_valid     : per-requester valid
//   in0..in8     : requester data words
//   in_ready     : one-hot grant, bit i means in_i is consumed this cycle
//   out          : registered selected word
//   out_valid    : output stage holds a word
//   out_ready    : consumer accepts out this cycle
//   select       : index of the requester that produced out
//
// Optional build macro MUX9_ARB_STATS_EN adds:
//   xfer_count   : 16-bit wrapping count of accepted output words
//   starve_flag  : sticky, set once any requester waits 16 cycles ungranted
// ---------------------------------------------------------------------------
module mux9_rr_arbiter
   import mux9_arb_pkg::*;
#(
   parameter int size = 32
) (
   input  logic            CGRA_Clock,
   input  logic            CGRA_Reset,
   input  logic            CGRA_Enable,
   input  req_vec_t        in_valid,
   input  logic [size-1:0] in0,
   input  logic [size-1:0] in1,
   input  logic [size-1:0] in2,
   input  logic [size-1:0] in3,
   input  logic [size-1:0] in4,
   input  logic [size-1:0] in5,
   input  logic [size-1:0] in6,
   input  logic [size-1:0] in7,
   input  logic [size-1:0] in8,
   output req_vec_t        in_ready,
   output logic [size-1:0] out,
   output logic            out_valid,
   input  logic            out_ready,
   output sel_t            select
`ifdef MUX9_ARB_STATS_EN
   ,
   output logic [15:0]     xfer_count,
   output logic            starve_flag
`endif
);

   req_vec_t        grant_oh;
   sel_t            grant_idx;
   logic            any_req;
   logic            load;
   logic [size-1:0] win_word;

   ostage_t         state_q,  state_d;
   logic [size-1:0] out_q,    out_d;
   sel_t            select_q, select_d;
   sel_t            last_q,   last_d;

   rr_pick9 u_pick (
      .req       (in_valid),
      .last      (last_q),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   // The stage can take a word when empty or when the current word drains
   // this cycle; a stall blocks both directions.
   assign load     = CGRA_Enable & ((state_q == ST_EMPTY) | out_ready);
   assign in_ready = (load && !CGRA_Reset) ? grant_oh : '0;

   always_comb begin
      case (grant_idx)
         4'd0:    win_word = in0;
         4'd1:    win_word = in1;
         4'd2:    win_word = in2;
         4'd3:    win_word = in3;
         4'd4:    win_word = in4;
         4'd5:    win_word = in5;
         4'd6:    win_word = in6;
         4'd7:    win_word = in7;
         4'd8:    win_word = in8;
         default: win_word = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      select_d = select_q;
      last_d   = last_q;
      if (load) begin
         if (any_req) begin
            state_d  = ST_FULL;
            out_d    = win_word;
            select_d = grant_idx;
            last_d   = grant_idx;
         end else begin
            // Word drained (or stage already empty); data and select hold.
            state_d = ST_EMPTY;
         end
      end
   end

   always_ff @(posedge CGRA_Clock) begin
      if (CGRA_Reset) begin
         state_q  <= ST_EMPTY;
         out_q    <= '0;
         select_q <= '0;
         last_q   <= RST_LAST_GRANT;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         select_q <= select_d;
         last_q   <= last_d;
      end
   end

   assign out       = out_q;
   assign out_valid = (state_q == ST_FULL);
   assign select    = select_q;

`ifdef MUX9_ARB_STATS_EN
   logic [15:0] xfer_count_q, xfer_count_d;
   logic        starve_q,     starve_d;
   req_vec_t    starve_hit;

   assign xfer_count_d = (out_valid && out_ready && CGRA_Enable)
                         ? xfer_count_q + 16'd1 : xfer_count_q;

   // Per-requester wait counter saturating at 16; cleared on grant or drop.
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_wait
      logic [4:0] wait_q, wait_d;

      always_comb begin
         wait_d = wait_q;
         if (CGRA_Enable) begin
            if (!in_valid[gi] || in_ready[gi]) begin
               wait_d = '0;
            end else if (wait_q != 5'd16) begin
               wait_d = wait_q + 5'd1;
            end
         end
      end

      always_ff @(posedge CGRA_Clock) begin
         if (CGRA_Reset) begin
            wait_q <= '0;
         end else begin
            wait_q <= wait_d;
         end
      end

      assign starve_hit[gi] = (wait_d == 5'd16);
   end

   assign starve_d = starve_q | (|starve_hit);

   always_ff @(posedge CGRA_Clock) begin
      if (CGRA_Reset) begin
         xfer_count_q <= '0;
         starve_q     <= 1'b0;
      end else begin
         xfer_count_q <= xfer_count_d;
         starve_q     <= starve_d;
      end
   end

   assign xfer_count  = xfer_count_q;
   assign starve_flag = starve_q;
`endif

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux9_rr_arbiter
// Self-checking bench for mux9_rr_arbiter (default build). Each granted word
// is pushed to a scoreboard queue when the grant is seen and popped when the
// output register updates; per-scenario tasks add explicit expectations.
// ---------------------------------------------------------------------------
module tb_mux9_rr_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, ordy;
   logic [8:0]  ivalid;
   logic [31:0] din [9];
   logic [8:0]  in_ready;
   logic [31:0] out;
   logic        out_valid;
   logic [3:0]  select;

   mux9_rr_arbiter #(.size(32)) dut (
      .CGRA_Clock  (clk),
      .CGRA_Reset  (rst),
      .CGRA_Enable (en),
      .in_valid    (ivalid),
      .in0 (din[0]), .in1 (din[1]), .in2 (din[2]),
      .in3 (din[3]), .in4 (din[4]), .in5 (din[5]),
      .in6 (din[6]), .in7 (din[7]), .in8 (din[8]),
      .in_ready    (in_ready),
      .out         (out),
      .out_valid   (out_valid),
      .out_ready   (ordy),
      .select      (select)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
   } xfer_t;

   xfer_t       sbq[$];
   int          total = 0;
   int          bad   = 0;

   // reference state
   logic [3:0]  m_last;
   logic        m_valid;
   logic [31:0] m_out;
   logic [3:0]  m_sel;

   // One clock: entered and left at the falling edge with inputs applied.
   task automatic cycle();
      logic [8:0] exp_rdy;
      logic       ld;
      logic       found;
      int         w;
      xfer_t      e;
      #1;
      exp_rdy = '0;
      found   = 1'b0;
      w       = 0;
      ld      = en && (!m_valid || ordy);
      if (!rst && ld) begin
         for (int k = 1; k <= 9; k++) begin
            int c;
            c = (int'(m_last) + k) % 9;
            if (!found && ivalid[c]) begin
               found = 1'b1;
               w     = c;
            end
         end
         if (found) begin
            exp_rdy[w] = 1'b1;
            sbq.push_back('{d: din[w], s: 4'(w)});
         end
      end
      total++;
      if (in_ready !== exp_rdy) begin
         bad++;
         $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         m_valid = 1'b0;
         m_out   = '0;
         m_sel   = '0;
         m_last  = 4'd8;
         sbq.delete();
      end else if (ld) begin
         if (found) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard: got empty queue want entry");
            end else begin
               e       = sbq.pop_front();
               m_out   = e.d;
               m_sel   = e.s;
               m_last  = e.s;
               m_valid = 1'b1;
               $display("xfer sel=%0d data=%08h", e.s, e.d);
            end
         end else begin
            m_valid = 1'b0;
         end
      end
      total++;
      if (out_valid !== m_valid) begin
         bad++;
         $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
      end
      total++;
      if (out !== m_out) begin
         bad++;
         $display("FAIL out: got %08h want %08h", out, m_out);
      end
      total++;
      if (select !== m_sel) begin
         bad++;
         $display("FAIL select: got %0d want %0d", select, m_sel);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      total++;
      if (out_valid !== 1'b0 || out !== 32'h0 || select !== 4'd0) begin
         bad++;
         $display("FAIL reset_state: got v=%b out=%08h sel=%0d want v=0 out=0 sel=0",
                  out_valid, out, select);
      end
      rst = 1'b0;
   endtask

   task automatic test_all_valid();
      ivalid = 9'h1FF;
      ordy   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         total++;
         if (select !== 4'(k % 9) || out !== 32'hA0 + 32'(k % 9)) begin
            bad++;
            $display("FAIL all_valid_order: got sel=%0d out=%08h want sel=%0d out=%08h",
                     select, out, k % 9, 32'hA0 + 32'(k % 9));
         end
      end
   endtask

   task automatic test_lone();
      ivalid = 9'h010;
      ordy   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if (in_ready !== 9'h010) begin
            bad++;
            $display("FAIL lone_ready: got %b want %b", in_ready, 9'h010);
         end
         #1;
         cycle();
         total++;
         if (select !== 4'd4 || out !== 32'hA4) begin
            bad++;
            $display("FAIL lone_out: got sel=%0d out=%08h want sel=4 out=000000a4", select, out);
         end
      end
   endtask

   task automatic test_hold();
      ivalid = 9'h006;
      ordy   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         total++;
         if (select !== 4'd4 || out !== 32'hA4 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold: got sel=%0d out=%08h v=%b want sel=4 out=000000a4 v=1",
                     select, out, out_valid);
         end
      end
      ordy = 1'b1;
      cycle();
      total++;
      if (select !== 4'd1) begin
         bad++;
         $display("FAIL hold_release1: got sel=%0d want sel=1", select);
      end
      cycle();
      total++;
      if (select !== 4'd2) begin
         bad++;
         $display("FAIL hold_release2: got sel=%0d want sel=2", select);
      end
   endtask

   task automatic test_wrap();
      ordy   = 1'b1;
      ivalid = 9'h100;
      cycle();
      ivalid = 9'h101;
      cycle();
      total++;
      if (select !== 4'd0 || out !== 32'hA0) begin
         bad++;
         $display("FAIL wrap_first: got sel=%0d out=%08h want sel=0 out=000000a0", select, out);
      end
      cycle();
      total++;
      if (select !== 4'd8 || out !== 32'hA8) begin
         bad++;
         $display("FAIL wrap_second: got sel=%0d out=%08h want sel=8 out=000000a8", select, out);
      end
   endtask

   task automatic test_reset_mid();
      ordy   = 1'b1;
      ivalid = 9'h1FF;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      total++;
      if (out_valid !== 1'b0 || out !== 32'h0 || select !== 4'd0) begin
         bad++;
         $display("FAIL reset_mid: got v=%b out=%08h sel=%0d want v=0 out=0 sel=0",
                  out_valid, out, select);
      end
      rst    = 1'b0;
      ivalid = 9'h0A4;
      cycle();
      total++;
      if (select !== 4'd2 || out !== 32'hA2) begin
         bad++;
         $display("FAIL reset_first_grant: got sel=%0d out=%08h want sel=2 out=000000a2",
                  select, out);
      end
   endtask

   task automatic test_enable();
      logic [3:0]  hold_sel;
      logic [31:0] hold_out;
      ordy   = 1'b1;
      ivalid = 9'h1FF;
      cycle();
      hold_sel = m_sel;
      hold_out = m_out;
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if (in_ready !== 9'h000) begin
            bad++;
            $display("FAIL stall_ready: got %b want 000000000", in_ready);
         end
         #1;
         cycle();
         total++;
         if (select !== hold_sel || out !== hold_out || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: got sel=%0d out=%08h v=%b want sel=%0d out=%08h v=1",
                     select, out, out_valid, hold_sel, hold_out);
         end
      end
      en = 1'b1;
      cycle();
      total++;
      if (select !== 4'((int'(hold_sel) + 1) % 9)) begin
         bad++;
         $display("FAIL stall_resume: got sel=%0d want sel=%0d",
                  select, (int'(hold_sel) + 1) % 9);
      end
   endtask

   task automatic test_drain();
      ordy   = 1'b1;
      ivalid = 9'h000;
      cycle();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain: got v=%b want v=0", out_valid);
      end
      cycle();
   endtask

   task automatic test_random();
      for (int k = 0; k < 80; k++) begin
         ivalid = 9'($urandom);
         ordy   = ($urandom % 3) != 0;
         en     = ($urandom % 5) != 0;
         for (int i = 0; i < 9; i++) din[i] = $urandom;
         cycle();
      end
      en = 1'b1;
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b1;
      ordy    = 1'b0;
      ivalid  = '0;
      for (int i = 0; i < 9; i++) din[i] = 32'hA0 + 32'(i);
      m_last  = 4'd8;
      m_valid = 1'b0;
      m_out   = '0;
      m_sel   = '0;
      @(negedge clk);
      test_reset();
      test_all_valid();
      test_lone();
      test_hold();
      test_wrap();
      test_reset_mid();
      test_enable();
      test_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux9_rr_arbiter.md
Name: mux9_rr_arbiter

Overview:
- Round-robin arbiter and scheduler for the shared 9-input, 32-bit word multiplexer in a CGRA functional-unit input path.
- Nine requesters present valid/data. The block grants one per cycle, drives the 4-bit mux select and registers the selected word into a single-entry output stage with a valid/ready handshake.
- Sits between the producer-side interconnect ports and a consuming FU or register.

Parameters:
- size, 32, data width of each input and of the output word
- NUM_IN, 9, number of requesters; fixed at 9 in this revision
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_IN

Ports:
- CGRA_Clock  input  1  single clock; all state updates on the rising edge
- CGRA_Reset  input  1  synchronous, active-high reset
- CGRA_Enable  input  1  global stall; when low, no transfers occur and all state holds
- in_valid  input  9  per-requester valid; bit i belongs to in_i
- in0..in8  input  size each  requester data words
- in_ready  output  9  one-hot grant/accept; bit i high means in_i is consumed this cycle
- out  output  size  registered selected word
- out_valid  output  1  output stage holds a word
- out_ready  input  1  consumer accepts out this cycle
- select  output  SEL_W  index of the requester that produced the current out word; drives the mux select

Behaviour:
- Reset values (CGRA_Reset high at the clock edge):
  - out_valid=0, out=0, select=0, last_grant=8.
  - in_ready is held all-zero while CGRA_Reset is high.
  - A word in flight is discarded, and no in_ready pulse occurs in that cycle.
- Output stage has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load = CGRA_Enable & (!out_valid | out_ready).
- Arbitration is combinational:
  - Priority order starts at last_grant+1 and wraps from 8 to 0.
  - The winner is the first index with in_valid set.
  - At most one in_ready bit may be high in any cycle.
- When load is high and any in_valid is high:
  - in_ready[w]=1 for the winner w only.
  - On the clock edge: out<=in_w, select<=w, last_grant<=w, out_valid<=1.
- When load is high and no in_valid is high:
  - in_ready=0.
  - out_valid<=0; out and select hold their values.
- When load is low: in_ready=0 and all registers hold.
- Latency is one cycle from grant to out_valid. Throughput is one word per cycle when out_ready is held high (a simultaneous drain and fill is allowed).
- Transitions: EMPTY->FULL on a grant; FULL->FULL on an accept with a new grant; FULL->EMPTY on an accept with no request; FULL holds while out_ready=0.
- Requester rule: in_i and in_valid[i] must stay stable while valid is high and in_ready[i] is low. Asserting in_valid must not depend on in_ready.
- select only takes values 0..8. The values 9..15 are never driven.
- Only the granted requester advances last_grant. A lone requester may be granted on every cycle.
- CGRA_Enable low overrides out_ready: a word is not considered consumed while the block is stalled.

Optional Feature:
- Macro: MUX9_ARB_STATS_EN
- With the macro defined:
  - Adds output xfer_count[15:0], which increments on every out_valid & out_ready & CGRA_Enable cycle.
  - The counter wraps from 0xFFFF to 0 and resets to 0.
  - Adds output starve_flag, which goes high once any requester has had valid high for 16 consecutive cycles without a grant. It is sticky until reset.
- Without the macro: these ports and their logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package mux9_arb_pkg holds:
  - constants NUM_IN=9, SEL_W=4, RST_LAST_GRANT=4'd8;
  - typedef sel_t (logic [SEL_W-1:0]);
  - typedef req_vec_t (logic [NUM_IN-1:0]).
- Sub-module rr_pick9 is purely combinational.
  - Inputs: req_vec_t and the last pointer.
  - Outputs: the one-hot grant, the binary index, and any_req.
- The top level contains the output register, the load logic and the optional stats logic.

Test Plan:
- Reset, then in_valid=9'h1FF with in_i=32'hA0+i and out_ready=1 -> outputs in order in0..in8 then in0, one per cycle; select=0,1,..,8,0; each in_ready is one-hot.
- Only in4 valid for 5 cycles with out_ready=1 -> in_ready[4] high every cycle; out=in4 and select=4 for 5 consecutive cycles.
- out_ready=0 with out_valid=1 and in_valid=9'h006 -> out and select hold, in_ready=0; after out_ready=1, in1 is granted and then in2.
- last_grant=8 with in_valid bits 8 and 0 set -> in0 wins (pointer wraps); the next cycle in8 wins.
- Assert CGRA_Reset mid-stream with out_valid=1 -> next cycle out_valid=0, out=0, select=0; the first grant after reset goes to the lowest valid index starting from 0.
- CGRA_Enable=0 for 3 cycles with requests pending and out_ready=1 -> in_ready=0 and out and select unchanged; transfers resume the cycle after enable returns high.
